// File: rtl/idu_pkg.sv
// Shared types and constants for the RV32I instruction decode unit.
// Holds the micro-op class enum, opcode encodings and the decode FSM states.
package idu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        OP_LUI    = 4'd0,
        OP_AUIPC  = 4'd1,
        OP_JAL    = 4'd2,
        OP_JALR   = 4'd3,
        OP_BRANCH = 4'd4,
        OP_LOAD   = 4'd5,
        OP_STORE  = 4'd6,
        OP_OPIMM  = 4'd7,
        OP_OP     = 4'd8,
        OP_FENCE  = 4'd9,
        OP_SYSTEM = 4'd10,
        OP_ILL    = 4'd11
    } op_e;

    typedef enum logic {
        RUN   = 1'b0,
        SLEEP = 1'b1
    } state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] WFI_ENC = 32'h1050_0073;

    typedef struct packed {
        op_e         op;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] imm;
        logic        ill;
    } uop_t;

    function automatic logic writes_rd(input op_e op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_OPIMM, OP_OP};
    endfunction

endpackage

// File: rtl/idu_dec.sv
// Combinational RV32I field extraction: instruction word to micro-op.
// Illegal encodings come out as OP_ILL with a zero immediate and no rd write.
module idu_dec
    import idu_pkg::*;
(
    input  logic [31:0] ins,
    output uop_t        uop,
    output logic        is_wfi
);

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'h000};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    assign is_wfi = (ins == WFI_ENC);

    // NOTE: every field gets a default before the case so no path can infer a latch.
    always_comb begin
        uop          = '0;
        uop.op       = OP_ILL;
        uop.funct3   = ins[14:12];
        uop.funct7b5 = ins[30];
        uop.rs1      = ins[19:15];
        uop.rs2      = ins[24:20];
        uop.rd       = ins[11:7];
        uop.imm      = '0;

        // Every opcode constant ends in 2'b11, so compressed encodings fall to default.
        case (ins[6:0])
            OPC_LUI:    begin uop.op = OP_LUI;    uop.imm = imm_u; end
            OPC_AUIPC:  begin uop.op = OP_AUIPC;  uop.imm = imm_u; end
            OPC_JAL:    begin uop.op = OP_JAL;    uop.imm = imm_j; end
            OPC_JALR:   begin uop.op = OP_JALR;   uop.imm = imm_i; end
            OPC_BRANCH: begin uop.op = OP_BRANCH; uop.imm = imm_b; end
            OPC_LOAD:   begin uop.op = OP_LOAD;   uop.imm = imm_i; end
            OPC_STORE:  begin uop.op = OP_STORE;  uop.imm = imm_s; end
            OPC_OPIMM:  begin uop.op = OP_OPIMM;  uop.imm = imm_i; end
            OPC_FENCE:  begin uop.op = OP_FENCE;  uop.imm = imm_i; end
            OPC_SYSTEM: begin uop.op = OP_SYSTEM; uop.imm = imm_i; end
            OPC_OP: begin
                if (ins[31:25] == 7'h00 || ins[31:25] == 7'h20) begin
                    uop.op = OP_OP;
                end
            end
            default: ;
        endcase

        uop.ill   = (uop.op == OP_ILL);
        uop.rd_we = writes_rd(uop.op) && (uop.rd != 5'd0);
    end

endmodule

// File: rtl/idu.sv
// Instruction decode stage: fetch handshake, WFI sleep FSM and the registered
// micro-op presented to the ALU, with branch-redirect and start kill.
module idu
    import idu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start_vld,
    input  logic            ifu_idu_vld,
    input  logic [31:0]     ifu_idu_ins,
    input  logic [XLEN-1:0] ifu_idu_pc,
    output logic            idu_ifu_rdy,
    output logic            idu_ifu_wfi,
    input  logic            alu_ifu_br_vld,
    input  logic            alu_idu_rdy,
    output logic            idu_alu_vld,
    output logic [XLEN-1:0] idu_alu_pc,
    output op_e             idu_alu_op,
    output logic [2:0]      idu_alu_funct3,
    output logic            idu_alu_funct7b5,
    output logic [4:0]      idu_alu_rs1,
    output logic [4:0]      idu_alu_rs2,
    output logic [4:0]      idu_alu_rd,
    output logic            idu_alu_rd_we,
    output logic [31:0]     idu_alu_imm,
    output logic            idu_alu_ill
);

    state_e          state_q;
    state_e          state_d;
    logic            vld_q;
    uop_t            uop_q;
    logic [XLEN-1:0] pc_q;

    uop_t dec_uop;
    logic dec_wfi;
    logic accept;
    logic wfi_take;
    logic load;
    logic kill;

    idu_dec u_dec (
        .ins    (ifu_idu_ins),
        .uop    (dec_uop),
        .is_wfi (dec_wfi)
    );

    assign kill = alu_ifu_br_vld | start_vld;

    always_comb begin
        state_d     = state_q;
        idu_ifu_rdy = (state_q == RUN) & ~alu_ifu_br_vld & (~vld_q | alu_idu_rdy);
        accept      = ifu_idu_vld & idu_ifu_rdy;
        wfi_take    = accept & dec_wfi;
        load        = accept & ~dec_wfi & ~kill;
        idu_ifu_wfi = ((state_q == SLEEP) & ~start_vld) | wfi_take;

        case (state_q)
            RUN:     if (wfi_take && !start_vld) state_d = SLEEP;
            SLEEP:   if (start_vld) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
        end else if (kill) begin
            vld_q <= 1'b0;
        end else if (load) begin
            vld_q <= 1'b1;
        end else if (alu_idu_rdy) begin
            vld_q <= 1'b0;
        end
    end

    // NOTE: the payload is reset too because the ALU-side data outputs must read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uop_q <= '0;
            pc_q  <= '0;
        end else if (load) begin
            uop_q <= dec_uop;
            pc_q  <= ifu_idu_pc;
        end
    end

    assign idu_alu_vld      = vld_q;
    assign idu_alu_pc       = pc_q;
    assign idu_alu_op       = uop_q.op;
    assign idu_alu_funct3   = uop_q.funct3;
    assign idu_alu_funct7b5 = uop_q.funct7b5;
    assign idu_alu_rs1      = uop_q.rs1;
    assign idu_alu_rs2      = uop_q.rs2;
    assign idu_alu_rd       = uop_q.rd;
    assign idu_alu_rd_we    = uop_q.rd_we;
    assign idu_alu_imm      = uop_q.imm;
    assign idu_alu_ill      = uop_q.ill;

endmodule

// File: tb/tb_idu.sv
// Scoreboard bench for idu: an ISA-level reference decoder and a one-slot
// pipeline model predict every handshake signal and every retired micro-op.
module tb_idu;
    import idu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_vld = 1'b0;
    logic        ifu_idu_vld = 1'b0;
    logic [31:0] ifu_idu_ins = '0;
    logic [31:0] ifu_idu_pc = '0;
    logic        alu_ifu_br_vld = 1'b0;
    logic        alu_idu_rdy = 1'b0;
    logic        idu_ifu_rdy;
    logic        idu_ifu_wfi;
    logic        idu_alu_vld;
    logic [31:0] idu_alu_pc;
    op_e         idu_alu_op;
    logic [2:0]  idu_alu_funct3;
    logic        idu_alu_funct7b5;
    logic [4:0]  idu_alu_rs1;
    logic [4:0]  idu_alu_rs2;
    logic [4:0]  idu_alu_rd;
    logic        idu_alu_rd_we;
    logic [31:0] idu_alu_imm;
    logic        idu_alu_ill;

    idu dut (
        .clk              (clk),
        .rst              (rst),
        .start_vld        (start_vld),
        .ifu_idu_vld      (ifu_idu_vld),
        .ifu_idu_ins      (ifu_idu_ins),
        .ifu_idu_pc       (ifu_idu_pc),
        .idu_ifu_rdy      (idu_ifu_rdy),
        .idu_ifu_wfi      (idu_ifu_wfi),
        .alu_ifu_br_vld   (alu_ifu_br_vld),
        .alu_idu_rdy      (alu_idu_rdy),
        .idu_alu_vld      (idu_alu_vld),
        .idu_alu_pc       (idu_alu_pc),
        .idu_alu_op       (idu_alu_op),
        .idu_alu_funct3   (idu_alu_funct3),
        .idu_alu_funct7b5 (idu_alu_funct7b5),
        .idu_alu_rs1      (idu_alu_rs1),
        .idu_alu_rs2      (idu_alu_rs2),
        .idu_alu_rd       (idu_alu_rd),
        .idu_alu_rd_we    (idu_alu_rd_we),
        .idu_alu_imm      (idu_alu_imm),
        .idu_alu_ill      (idu_alu_ill)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        op_e         op;
        logic [2:0]  f3;
        logic        f7b5;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    bit   m_sleep = 1'b0;
    bit   mon_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint u(input logic [31:0] x);
        return longint'(x);
    endfunction

    // Reference decoder: immediates as signed sums of weighted instruction fields.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t   e;
        longint v;
        v      = 0;
        e.pc   = pc;
        e.f3   = w[14:12];
        e.f7b5 = w[30];
        e.rs1  = w[19:15];
        e.rs2  = w[24:20];
        e.rd   = w[11:7];
        e.op   = OP_ILL;
        case (w[6:0])
            7'h37: begin e.op = OP_LUI;    v = u(w[31:12]) * 4096; end
            7'h17: begin e.op = OP_AUIPC;  v = u(w[31:12]) * 4096; end
            7'h6F: begin
                e.op = OP_JAL;
                v = -u(w[31]) * (1 << 20) + u(w[19:12]) * 4096 + u(w[20]) * 2048 + u(w[30:21]) * 2;
            end
            7'h63: begin
                e.op = OP_BRANCH;
                v = -u(w[31]) * 4096 + u(w[7]) * 2048 + u(w[30:25]) * 32 + u(w[11:8]) * 2;
            end
            7'h23: begin
                e.op = OP_STORE;
                v = u({w[31:25], w[11:7]}) - u(w[31]) * 4096;
            end
            7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: begin
                case (w[6:0])
                    7'h67:   e.op = OP_JALR;
                    7'h03:   e.op = OP_LOAD;
                    7'h13:   e.op = OP_OPIMM;
                    7'h0F:   e.op = OP_FENCE;
                    default: e.op = OP_SYSTEM;
                endcase
                v = u(w[31:20]) - u(w[31]) * 4096;
            end
            7'h33: if (w[31:25] == 7'h00 || w[31:25] == 7'h20) e.op = OP_OP;
            default: ;
        endcase
        e.imm = 32'(v);
        e.ill = (e.op == OP_ILL);
        e.we  = (e.op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_OPIMM, OP_OP})
                && (w[11:7] != 5'd0);
        return e;
    endfunction

    function automatic bit model_rdy();
        return !m_sleep && !alu_ifu_br_vld && (exp_q.size() == 0 || alu_idu_rdy);
    endfunction

    // Monitor: mid-cycle, compares handshake outputs and the presented op against the model.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                bit r;
                bit w;
                r = model_rdy();
                w = (m_sleep && !start_vld) ||
                    (!m_sleep && ifu_idu_vld && r && ifu_idu_ins == WFI_ENC);
                check("ifu_rdy", idu_ifu_rdy, r);
                check("ifu_wfi", idu_ifu_wfi, w);
                check("alu_vld", idu_alu_vld, exp_q.size() != 0);
                if (idu_alu_vld && exp_q.size() != 0) begin
                    check("op_pc", idu_alu_pc, exp_q[0].pc);
                    check("op_class", idu_alu_op, exp_q[0].op);
                    check("op_funct3", idu_alu_funct3, exp_q[0].f3);
                    check("op_funct7b5", idu_alu_funct7b5, exp_q[0].f7b5);
                    check("op_rs1", idu_alu_rs1, exp_q[0].rs1);
                    check("op_rs2", idu_alu_rs2, exp_q[0].rs2);
                    check("op_rd", idu_alu_rd, exp_q[0].rd);
                    check("op_rd_we", idu_alu_rd_we, exp_q[0].we);
                    check("op_imm", idu_alu_imm, exp_q[0].imm);
                    check("op_ill", idu_alu_ill, exp_q[0].ill);
                end
            end
        end
    end

    // One cycle of stimulus: drive after the falling edge, advance the model for the next rising edge.
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit ardy, input bit br, input bit st);
        bit acc;
        bit is_w;
        @(negedge clk);
        #1;
        ifu_idu_vld    = v;
        ifu_idu_ins    = ins;
        ifu_idu_pc     = pc;
        alu_idu_rdy    = ardy;
        alu_ifu_br_vld = br;
        start_vld      = st;
        #2;
        acc  = v && model_rdy();
        is_w = (ins == WFI_ENC);
        if (br || st) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() != 0 && ardy) void'(exp_q.pop_front());
            if (acc && !is_w) exp_q.push_back(ref_decode(ins, pc));
        end
        if (m_sleep) begin
            if (st) m_sleep = 1'b0;
        end else if (acc && is_w && !st) begin
            m_sleep = 1'b1;
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_ins();
        logic [6:0]  opcs [11];
        logic [31:0] w;
        int          sel;
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        sel  = $urandom_range(0, 15);
        if (sel == 0) return WFI_ENC;
        w = $urandom();
        if (sel == 1) return w;
        w[6:0] = opcs[$urandom_range(0, 10)];
        if (w[6:0] == 7'h33) begin
            case ($urandom_range(0, 2))
                0:       w[31:25] = 7'h00;
                1:       w[31:25] = 7'h20;
                default: ;
            endcase
        end
        return w;
    endfunction

    task automatic random_phase(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bit st;
            st = m_sleep && exp_q.size() == 0 && ($urandom_range(0, 2) == 0);
            step($urandom_range(0, 3) != 0, rand_ins(), $urandom() & 32'hFFFF_FFFC,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, st);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vld"}, idu_alu_vld, 1'b0);
        check({tag, "_wfi"}, idu_ifu_wfi, 1'b0);
        check({tag, "_rdy"}, idu_ifu_rdy, 1'b1);
        check({tag, "_pc"}, idu_alu_pc, 32'h0);
        check({tag, "_op"}, idu_alu_op, 4'h0);
        check({tag, "_fields"}, {idu_alu_funct3, idu_alu_funct7b5, idu_alu_rs1, idu_alu_rs2, idu_alu_rd}, 19'h0);
        check({tag, "_rd_we"}, idu_alu_rd_we, 1'b0);
        check({tag, "_imm"}, idu_alu_imm, 32'h0);
        check({tag, "_ill"}, idu_alu_ill, 1'b0);
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Back-to-back addi / add with the ALU always ready.
        step(1, 32'h0050_0093, 32'h100, 1, 0, 0);
        after_edge();
        check("addi_vld", idu_alu_vld, 1'b1);
        check("addi_op", idu_alu_op, OP_OPIMM);
        check("addi_imm", idu_alu_imm, 32'd5);
        check("addi_rd", idu_alu_rd, 5'd1);
        step(1, 32'h0010_8133, 32'h104, 1, 0, 0);
        after_edge();
        check("add_op", idu_alu_op, OP_OP);
        check("add_rs", {idu_alu_rs1, idu_alu_rs2}, {5'd1, 5'd1});
        check("add_rd", idu_alu_rd, 5'd2);

        // ALU stall for three cycles, then release accepts the waiting slot.
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h0000_0013, 32'h108, 0, 0, 0);
            after_edge();
            check("stall_rdy", idu_ifu_rdy, 1'b0);
            check("stall_pc", idu_alu_pc, 32'h104);
        end
        step(1, 32'h0000_0013, 32'h108, 1, 0, 0);
        after_edge();
        check("release_pc", idu_alu_pc, 32'h108);

        // WFI goes to sleep and stays there until start.
        step(1, WFI_ENC, 32'h10C, 1, 0, 0);
        after_edge();
        check("wfi_no_op", idu_alu_vld, 1'b0);
        check("wfi_asleep", idu_ifu_wfi, 1'b1);
        check("wfi_rdy", idu_ifu_rdy, 1'b0);
        for (int i = 0; i < 4; i++) step(1, 32'h0050_0093, 32'h110, 1, 0, 0);
        step(1, 32'h0050_0093, 32'h110, 1, 0, 1);
        after_edge();
        check("wake_wfi", idu_ifu_wfi, 1'b0);
        check("wake_rdy", idu_ifu_rdy, 1'b1);

        // Branch redirect kills the registered op and blocks acceptance.
        step(1, 32'h0050_0093, 32'h200, 0, 0, 0);
        step(1, 32'h0010_8133, 32'h204, 0, 1, 0);
        after_edge();
        check("br_kill_vld", idu_alu_vld, 1'b0);

        // Immediate formats and illegal encodings.
        step(1, 32'hFE00_0EE3, 32'h300, 1, 0, 0);
        after_edge();
        check("beq_imm", idu_alu_imm, 32'hFFFF_FFFC);
        step(1, 32'h0040_006F, 32'h304, 1, 0, 0);
        after_edge();
        check("jal_imm", idu_alu_imm, 32'd4);
        step(1, 32'h1234_5037, 32'h308, 1, 0, 0);
        after_edge();
        check("lui_imm", idu_alu_imm, 32'h1234_5000);
        step(1, 32'h0000_0000, 32'h30C, 1, 0, 0);
        after_edge();
        check("ill0", {idu_alu_ill, idu_alu_op, idu_alu_rd_we}, {1'b1, OP_ILL, 1'b0});
        step(1, 32'h0000_007F, 32'h310, 1, 0, 0);
        after_edge();
        check("ill7f", {idu_alu_ill, idu_alu_op, idu_alu_rd_we}, {1'b1, OP_ILL, 1'b0});

        // Start while running only clears the registered op.
        step(1, 32'h0050_0093, 32'h400, 0, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0, 1);
        after_edge();
        check("start_run_vld", idu_alu_vld, 1'b0);
        check("start_run_rdy", idu_ifu_rdy, 1'b1);

        random_phase(2000);

        // Asynchronous reset with an op held in the register.
        step(1, 32'h0050_0093, 32'h500, 0, 0, 0);
        step(1, 32'h0010_8133, 32'h504, 0, 0, 0);
        @(negedge clk);
        #1;
        ifu_idu_vld = 1'b0;
        rst         = 1'b1;
        exp_q.delete();
        m_sleep     = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;

        random_phase(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
